// File: rtl/lru_ch_arbiter.sv
// Least-recently-granted channel arbiter with a per-ID busy scoreboard.
// One grant per three cycles: IDLE decides, GRANT samples select, GAP settles.
module lru_ch_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  p_lru_join_ch,
   input  logic        p_sel_val,
   input  logic [3:0]  p_sel_req_id,
   input  logic        p_cmp_val,
   input  logic [3:0]  p_cmp_id,
   input  logic        p_stall,
   output logic        p_arb_val,
   output logic [1:0]  p_arb_ch,
   output logic [15:0] p_req_id_enb,
   output logic [7:0]  p_lru_order,
   output logic        p_err
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t      state, state_n;
   logic        arb_val_n;
   logic [1:0]  arb_ch_n;
   logic [1:0]  cand;
   logic        found;
   logic [1:0]  gslot;
   logic [7:0]  lru_n;
   logic [15:0] busy, busy_n;
   logic        err_n;
   logic        sel_ok;
   logic        cmp_hit;

   assign sel_ok       = (state == GRANT) && p_sel_val;
   assign cmp_hit      = p_cmp_val && busy[p_cmp_id];
   assign p_req_id_enb = ~busy;

   // Scan from the LRU slot upward for the first joined channel
   always_comb begin
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!found && p_lru_join_ch[p_lru_order[2*i +: 2]]) begin
            found = 1'b1;
            cand  = p_lru_order[2*i +: 2];
         end
      end
   end

   always_comb begin
      gslot = '0;
      for (int i = 0; i < 4; i++) begin
         if (p_lru_order[2*i +: 2] == p_arb_ch)
            gslot = 2'(i);
      end
   end

   // Granted channel moves to MRU; everything above it slides down a slot
   always_comb begin
      lru_n = p_lru_order;
      if (sel_ok) begin
         for (int i = 0; i < 3; i++) begin
            if (2'(i) >= gslot)
               lru_n[2*i +: 2] = p_lru_order[2*i+2 +: 2];
         end
         lru_n[7:6] = p_arb_ch;
      end
   end

   always_comb begin
      busy_n = busy;
      if (cmp_hit)
         busy_n[p_cmp_id] = 1'b0;
      if (sel_ok)
         busy_n[p_sel_req_id] = 1'b1;
   end

   always_comb begin
      err_n = p_err;
      if (p_cmp_val && !busy[p_cmp_id])
         err_n = 1'b1;
      if (p_sel_val && (state != GRANT))
         err_n = 1'b1;
      if (sel_ok && busy[p_sel_req_id])
         err_n = 1'b1;
      if (sel_ok && p_cmp_val && (p_cmp_id == p_sel_req_id))
         err_n = 1'b1;
   end

   always_comb begin
      state_n   = state;
      arb_val_n = 1'b0;
      arb_ch_n  = p_arb_ch;
      unique case (state)
         IDLE: begin
            if (!p_stall && found) begin
               state_n   = GRANT;
               arb_val_n = 1'b1;
               arb_ch_n  = cand;
            end
         end
         GRANT:   state_n = GAP;
         GAP:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         p_arb_val   <= 1'b0;
         p_arb_ch    <= '0;
         busy        <= '0;
         p_lru_order <= 8'hE4;
         p_err       <= 1'b0;
      end else begin
         state       <= state_n;
         p_arb_val   <= arb_val_n;
         p_arb_ch    <= arb_ch_n;
         busy        <= busy_n;
         p_lru_order <= lru_n;
         p_err       <= err_n;
      end
   end

endmodule

// File: tb/tb_lru_ch_arbiter.sv
// Directed bench for lru_ch_arbiter with a grant scoreboard queue.
// Expected {channel, lru-after} pairs are queued before each grant is awaited.
module tb_lru_ch_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  p_lru_join_ch;
   logic        p_sel_val;
   logic [3:0]  p_sel_req_id;
   logic        p_cmp_val;
   logic [3:0]  p_cmp_id;
   logic        p_stall;
   logic        p_arb_val;
   logic [1:0]  p_arb_ch;
   logic [15:0] p_req_id_enb;
   logic [7:0]  p_lru_order;
   logic        p_err;

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;
   logic [9:0] sb[$];

   lru_ch_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .p_lru_join_ch(p_lru_join_ch),
      .p_sel_val    (p_sel_val),
      .p_sel_req_id (p_sel_req_id),
      .p_cmp_val    (p_cmp_val),
      .p_cmp_id     (p_cmp_id),
      .p_stall      (p_stall),
      .p_arb_val    (p_arb_val),
      .p_arb_ch     (p_arb_ch),
      .p_req_id_enb (p_req_id_enb),
      .p_lru_order  (p_lru_order),
      .p_err        (p_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic do_grant(input string tag, input logic [1:0] ch,
                           input int exp_cyc, input logic sel,
                           input logic [3:0] id, input logic [7:0] lru);
      int n;
      logic [9:0] e;
      sb.push_back({ch, lru});
      n = 0;
      while (p_arb_val !== 1'b1 && n < 12) begin
         step();
         n++;
      end
      e = sb.pop_front();
      if (p_arb_val !== 1'b1) begin
         check({tag, "_timeout"}, 32'(p_arb_val), 32'd1);
         return;
      end
      check({tag, "_ch"}, 32'(p_arb_ch), 32'(e[9:8]));
      if (exp_cyc >= 0)
         check({tag, "_cyc"}, cyc, exp_cyc);
      p_sel_val    = sel;
      p_sel_req_id = id;
      step();
      p_sel_val = 1'b0;
      check({tag, "_lru"}, 32'(p_lru_order), 32'(e[7:0]));
      check({tag, "_gap"}, 32'(p_arb_val), 32'd0);
   endtask

   task automatic complete(input logic [3:0] id);
      p_cmp_val = 1'b1;
      p_cmp_id  = id;
      step();
      p_cmp_val = 1'b0;
   endtask

   initial begin
      int c;
      logic seen;
      int n;
      rst           = 1'b1;
      p_lru_join_ch = '0;
      p_sel_val     = 1'b0;
      p_sel_req_id  = '0;
      p_cmp_val     = 1'b0;
      p_cmp_id      = '0;
      p_stall       = 1'b0;

      do_reset();
      check("rst_val", 32'(p_arb_val), 32'd0);
      check("rst_enb", 32'(p_req_id_enb), 32'hFFFF);
      check("rst_lru", 32'(p_lru_order), 32'hE4);
      check("rst_err", 32'(p_err), 32'd0);

      // round robin
      p_lru_join_ch = 4'hF;
      do_grant("rr0", 2'd0, 1, 1'b1, 4'd0, 8'h39);
      complete(4'd0);
      do_grant("rr1", 2'd1, 4, 1'b1, 4'd1, 8'h4E);
      complete(4'd1);
      do_grant("rr2", 2'd2, 7, 1'b1, 4'd2, 8'h93);
      complete(4'd2);
      do_grant("rr3", 2'd3, 10, 1'b1, 4'd3, 8'hE4);
      complete(4'd3);
      do_grant("rr4", 2'd0, 13, 1'b1, 4'd4, 8'h39);
      p_lru_join_ch = '0;
      complete(4'd4);
      check("rr_enb", 32'(p_req_id_enb), 32'hFFFF);
      check("rr_err", 32'(p_err), 32'd0);

      // scoreboard on ID 5
      p_lru_join_ch = 4'b0100;
      do_grant("sb5", 2'd2, -1, 1'b1, 4'd5, 8'h8D);
      p_lru_join_ch = '0;
      check("sb5_enb_gap", 32'(p_req_id_enb), 32'hFFDF);
      step();
      step();
      check("sb5_enb_held", 32'(p_req_id_enb), 32'hFFDF);
      complete(4'd5);
      check("sb5_enb_clr", 32'(p_req_id_enb), 32'hFFFF);
      check("sb5_err", 32'(p_err), 32'd0);

      // miss then re-grant of ch2
      p_lru_join_ch = 4'b0100;
      do_grant("miss", 2'd2, -1, 1'b0, 4'd6, 8'h8D);
      c = cyc - 1;
      check("miss_enb", 32'(p_req_id_enb), 32'hFFFF);
      do_grant("regrant", 2'd2, c + 3, 1'b1, 4'd6, 8'h8D);
      p_lru_join_ch = '0;
      complete(4'd6);
      check("regrant_enb", 32'(p_req_id_enb), 32'hFFFF);

      // completion to a non-busy ID
      step();
      complete(4'd9);
      check("err_set", 32'(p_err), 32'd1);

      // stall holds off grants
      p_stall       = 1'b1;
      p_lru_join_ch = 4'hF;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (p_arb_val === 1'b1)
            seen = 1'b1;
      end
      check("stall_block", 32'(seen), 32'd0);
      p_stall = 1'b0;
      c = cyc;
      do_grant("unstall", 2'd1, c + 1, 1'b1, 4'd7, 8'h63);
      check("err_sticky", 32'(p_err), 32'd1);
      check("busy7", 32'(p_req_id_enb), 32'hFF7F);

      // asynchronous reset while a grant is live
      n = 0;
      while (p_arb_val !== 1'b1 && n < 12) begin
         step();
         n++;
      end
      check("mid_val", 32'(p_arb_val), 32'd1);
      check("mid_ch", 32'(p_arb_ch), 32'd3);
      rst = 1'b1;
      #1;
      check("arst_val", 32'(p_arb_val), 32'd0);
      check("arst_enb", 32'(p_req_id_enb), 32'hFFFF);
      check("arst_lru", 32'(p_lru_order), 32'hE4);
      check("arst_err", 32'(p_err), 32'd0);

      // sparse join from reset
      p_lru_join_ch = 4'b1010;
      do_reset();
      do_grant("sp0", 2'd1, 1, 1'b1, 4'd10, 8'h78);
      do_grant("sp1", 2'd3, 4, 1'b1, 4'd11, 8'hD8);
      do_grant("sp2", 2'd1, 7, 1'b1, 4'd12, 8'h78);
      check("sp_enb", 32'(p_req_id_enb), 32'hE3FF);
      check("sp_err", 32'(p_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/lru_ch_arbiter.md
Name: lru_ch_arbiter

Overview:
- Grant side of the request-select queue interface.
- Watches the per-channel pending vector (p_lru_join_ch) and issues channel grants (p_arb_val/p_arb_ch) in least-recently-granted order.
- Keeps a per-ID busy scoreboard that drives p_req_id_enb back to the queue: an ID is disabled from selection when selected, and re-enabled on completion.

Parameters:
- NCH, 4, number of channels; fixed at 4, p_arb_ch is 2 bits.
- NID, 16, number of request IDs; fixed at 16, IDs are 4 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- p_lru_join_ch  in  4  channels with at least one pending enabled request.
- p_sel_val  in  1  queue selected an entry for the current grant.
- p_sel_req_id  in  4  ID of the selected entry; valid with p_sel_val.
- p_cmp_val  in  1  completion for a previously selected ID.
- p_cmp_id  in  4  completed ID.
- p_stall  in  1  downstream not ready; blocks new grants.
- p_arb_val  out  1  grant valid; registered.
- p_arb_ch  out  2  granted channel; registered.
- p_req_id_enb  out  16  per-ID selection enable; equals ~busy; registered.
- p_lru_order  out  8  LRU state. [1:0] = least recently granted channel, [7:6] = most recently granted.
- p_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - p_arb_val=0, p_arb_ch=0.
  - busy=0, so p_req_id_enb=16'hFFFF.
  - p_lru_order=8'hE4 (ch0 LRU, ch3 MRU).
  - p_err=0.
  - FSM in IDLE.
- LRU invariant: p_lru_order is always a permutation of {0,1,2,3}.
- Candidate selection: scan the order from [1:0] (LRU) upward; pick the first channel whose p_lru_join_ch bit is 1.
- FSM states are IDLE, GRANT and GAP.
  - IDLE: if p_stall=0 and p_lru_join_ch!=0, register p_arb_val=1 and p_arb_ch=candidate, then go to GRANT. Otherwise stay, with p_arb_val=0.
  - GRANT (p_arb_val=1 for exactly this one cycle):
    - Sample p_sel_val. If 1, move the granted channel to the MRU slot; channels above it shift down one slot, relative order kept. Set busy[p_sel_req_id]. LRU and busy updates are visible next cycle.
    - If p_sel_val=0 (stale grant / miss), LRU and busy are unchanged.
    - p_stall and p_lru_join_ch are ignored in this state.
    - Next state is GAP; p_arb_val=0 next cycle.
  - GAP: one dead cycle so the queue sees the updated p_req_id_enb and join vector. Then go to IDLE.
  - Resulting grant rate: at most one grant per 3 cycles.
- Grant-to-select latency: 1 cycle from the IDLE decision to the registered grant. p_sel_val is sampled in the same cycle as p_arb_val=1.
- Completions (any state): if p_cmp_val and busy[p_cmp_id], clear busy[p_cmp_id] next cycle.
- Simultaneous select and completion of different IDs: both take effect.
- Error conditions. Each sets p_err=1 from the next cycle; p_err stays 1 until reset. The affected bit is handled as stated.
  - p_cmp_val to a non-busy ID: no busy change.
  - p_sel_val outside GRANT: ignored.
  - p_sel_val in GRANT for an already-busy ID: busy stays 1; LRU is still updated.
  - Select and completion of the same ID in the same cycle: set wins, busy=1.
- Unknown or undriven inputs are not handled; the bench drives all inputs every cycle.

Test Plan:
- Reset: assert rst mid-GRANT -> immediately p_arb_val=0, p_req_id_enb=16'hFFFF, p_lru_order=8'hE4, p_err=0.
- Round robin: p_lru_join_ch=4'hF held; queue returns p_sel_val=1 with IDs 0,1,2,3,4 and completes each 1 cycle later -> grants ch0,1,2,3,0 on cycles 1,4,7,10,13; p_lru_order after the first grant = 8'h39.
- Sparse join: p_lru_join_ch=4'b1010 from reset -> grants ch1, ch3, ch1; p_lru_order goes E4 -> 78 -> D8 -> 78 (the ch1/ch3 order flips each grant; ch0 and ch2 stay in the bottom two slots).
- Scoreboard: select ID 5 -> p_req_id_enb[5]=0 from the GAP cycle. p_cmp_val with ID 5 three cycles later -> bit 5 returns to 1 the next cycle; p_err stays 0.
- Miss: grant ch2 with p_sel_val=0 -> p_lru_order unchanged, enb unchanged, ch2 re-granted 3 cycles later.
- Errors and stall:
  - p_cmp_val with ID 9 while idle -> p_err=1, held through later traffic.
  - p_stall=1 with p_lru_join_ch=4'hF -> p_arb_val stays 0 until p_stall falls, then a grant 1 cycle later.
